// File: rtl/opsel_pkg.sv
// Shared encodings and defaults for the operand-select stage.
// Forwarding is built in only when OPSEL_FORWARDING_EN is defined (see operand_select_stage).
package opsel_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_IMM_W = 16;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender: sign, zero or upper placement to WIDTH bits.
module imm_extend
    import opsel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] ext
);
    always_comb begin
        ext = '0;
        case (mode)
            EXT_ZERO:  ext = {{(WIDTH-IMM_W){1'b0}}, imm};
            EXT_UPPER: ext = {imm, {(WIDTH-IMM_W){1'b0}}};
            // reserved encoding falls back to sign extension
            default:   ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        endcase
    end
endmodule

// File: rtl/operand_select_stage.sv
// ID/EX operand select: forwarding muxes, immediate select and the operand register.
// Define OPSEL_FORWARDING_EN to honour fwd_a/fwd_b; otherwise operands come from the register file.
module operand_select_stage
    import opsel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       ext_mode,
    input  logic             alu_src,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] store_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] st;
    } ops_t;

    logic [WIDTH-1:0] next_a, next_rt, imm_ext;
    ops_t             nxt, ops_q;

`ifdef OPSEL_FORWARDING_EN
    always_comb begin
        next_a = rs_data;
        case (fwd_a)
            FWD_EXMEM: next_a = exmem_data;
            FWD_MEMWB: next_a = memwb_data;
            default:   next_a = rs_data;
        endcase
    end

    always_comb begin
        next_rt = rt_data;
        case (fwd_b)
            FWD_EXMEM: next_rt = exmem_data;
            FWD_MEMWB: next_rt = memwb_data;
            default:   next_rt = rt_data;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a, fwd_b, exmem_data, memwb_data};
    assign next_a     = rs_data;
    assign next_rt    = rt_data;
`endif

    imm_extend #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_ext (
        .imm  (imm),
        .mode (ext_mode),
        .ext  (imm_ext)
    );

    assign nxt = '{a: next_a, b: (alu_src ? imm_ext : next_rt), st: next_rt};

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q     <= '0;
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            ops_q     <= '0;
            out_valid <= 1'b0;
        end else if (stall) begin
            // only held valid instructions count, and the counter sticks at all-ones
            if (out_valid && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            ops_q     <= nxt;
            out_valid <= in_valid;
        end
    end

    assign op_a       = ops_q.a;
    assign op_b       = ops_q.b;
    assign store_data = ops_q.st;
endmodule

// File: tb/tb_operand_select_stage.sv
// Self-checking bench: directed corner cases plus random traffic against a behavioural model.
module tb_operand_select_stage;
    localparam int W  = 32;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset, in_valid, stall, flush, alu_src;
    logic [W-1:0]  rs_data, rt_data, exmem_data, memwb_data;
    logic [IW-1:0] imm;
    logic [1:0]    ext_mode, fwd_a, fwd_b;

    logic [W-1:0]  op_a, op_b, store_data, op_a4, op_b4, store_data4;
    logic          out_valid, out_valid4;
    logic [15:0]   stall_cnt;
    logic [3:0]    stall_cnt4;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [W-1:0] m_a, m_b, m_st;
    logic         m_v;
    int           m_cnt, m_cnt4;
    logic [W-1:0] held_a;

    always #5 clk = ~clk;

    operand_select_stage #(.WIDTH(W), .IMM_W(IW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .ext_mode(ext_mode),
        .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .op_a(op_a), .op_b(op_b), .store_data(store_data),
        .out_valid(out_valid), .stall_cnt(stall_cnt)
    );

    operand_select_stage #(.WIDTH(W), .IMM_W(IW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .ext_mode(ext_mode),
        .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .op_a(op_a4), .op_b(op_b4), .store_data(store_data4),
        .out_valid(out_valid4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // extension by arithmetic on the immediate's numeric value
    function automatic logic [W-1:0] ext_ref(input logic [IW-1:0] i, input logic [1:0] m);
        longint unsigned v;
        v = 64'(i);
        if (m == 2'd1) return W'(v);
        if (m == 2'd2) return W'(v * (64'd1 << (W - IW)));
        if (v >= (64'd1 << (IW - 1))) v = v + (64'd1 << W) - (64'd1 << IW);
        return W'(v);
    endfunction

    function automatic logic [W-1:0] src_ref(input logic [1:0] sel, input logic [W-1:0] rf,
                                             input logic [W-1:0] ex, input logic [W-1:0] mw);
`ifdef OPSEL_FORWARDING_EN
        if (sel == 2'd1) return ex;
        if (sel == 2'd2) return mw;
`endif
        return rf;
    endfunction

    // advance model on current inputs, take one edge, then compare everything
    task automatic step();
        logic [W-1:0] rt;
        rt = src_ref(fwd_b, rt_data, exmem_data, memwb_data);
        if (reset) begin
            m_a = '0; m_b = '0; m_st = '0; m_v = 1'b0; m_cnt = 0; m_cnt4 = 0;
        end else if (flush) begin
            m_a = '0; m_b = '0; m_st = '0; m_v = 1'b0;
        end else if (stall) begin
            if (m_v) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end else begin
            m_a  = src_ref(fwd_a, rs_data, exmem_data, memwb_data);
            m_b  = alu_src ? ext_ref(imm, ext_mode) : rt;
            m_st = rt;
            m_v  = in_valid;
        end
        @(posedge clk);
        #1;
        chk("op_a", 64'(op_a), 64'(m_a));
        chk("op_b", 64'(op_b), 64'(m_b));
        chk("store_data", 64'(store_data), 64'(m_st));
        chk("out_valid", 64'(out_valid), 64'(m_v));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("op_a_c4", 64'(op_a4), 64'(m_a));
        chk("stall_cnt_c4", 64'(stall_cnt4), 64'(m_cnt4));
    endtask

    task automatic idle();
        reset = 0; in_valid = 0; stall = 0; flush = 0; alu_src = 0;
        rs_data = '0; rt_data = '0; exmem_data = '0; memwb_data = '0;
        imm = '0; ext_mode = 2'd0; fwd_a = 2'd0; fwd_b = 2'd0;
    endtask

    task automatic randomize_data();
        rs_data = $urandom; rt_data = $urandom; exmem_data = $urandom; memwb_data = $urandom;
        imm = IW'($urandom); ext_mode = 2'($urandom); alu_src = 1'($urandom);
        fwd_a = 2'($urandom); fwd_b = 2'($urandom); in_valid = 1'($urandom);
    endtask

    initial begin
        idle();
        m_a = '0; m_b = '0; m_st = '0; m_v = 1'b0; m_cnt = 0; m_cnt4 = 0;
        reset = 1; stall = 1; flush = 1;
        @(posedge clk); #1;
        stall = 0; flush = 0;
        step();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_cnt", 64'(stall_cnt), 64'd0);
        reset = 0;

        // immediate extension
        in_valid = 1; alu_src = 1; imm = 16'h8001;
        ext_mode = 2'b00; step(); chk("sext", 64'(op_b), 64'hFFFF8001);
        ext_mode = 2'b01; step(); chk("zext", 64'(op_b), 64'h00008001);
        ext_mode = 2'b10; step(); chk("upper", 64'(op_b), 64'h80010000);
        ext_mode = 2'b11; step(); chk("rsvd_ext", 64'(op_b), 64'hFFFF8001);
        imm = 16'h7FFF; ext_mode = 2'b00; step(); chk("sext_pos", 64'(op_b), 64'h00007FFF);

        // forwarding
        idle(); in_valid = 1;
        fwd_a = 2'b01; exmem_data = 32'h12345678; rs_data = '0;
        fwd_b = 2'b10; alu_src = 0; memwb_data = 32'hA5A5A5A5; rt_data = 32'h0BAD0BAD;
        step();
`ifdef OPSEL_FORWARDING_EN
        chk("fwd_a_exmem", 64'(op_a), 64'h12345678);
        chk("fwd_b_memwb", 64'(op_b), 64'hA5A5A5A5);
        chk("fwd_store", 64'(store_data), 64'hA5A5A5A5);
`else
        chk("nofwd_a", 64'(op_a), 64'h0);
        chk("nofwd_b", 64'(op_b), 64'h0BAD0BAD);
`endif
        fwd_a = 2'b01; exmem_data = 32'hDEADBEEF; rs_data = 32'h1;
        step();
`ifdef OPSEL_FORWARDING_EN
        chk("fwd_a_dead", 64'(op_a), 64'hDEADBEEF);
`else
        chk("nofwd_a_rs", 64'(op_a), 64'h1);
`endif

        // invalid instruction still loads data
        idle(); rs_data = 32'h55AA55AA; step();
        chk("inval_data", 64'(op_a), 64'h55AA55AA);
        chk("inval_valid", 64'(out_valid), 64'd0);

        // stall holds for 3 cycles while inputs change
        reset = 1; step(); reset = 0;
        randomize_data(); in_valid = 1; step();
        held_a = op_a;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_data(); step();
        end
        chk("stall_hold_a", 64'(op_a), 64'(held_a));
        chk("stall_cnt3", 64'(stall_cnt), 64'd3);

        // flush wins over stall, counter untouched
        flush = 1; step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_a", 64'(op_a), 64'd0);
        chk("flush_b", 64'(op_b), 64'd0);
        chk("flush_cnt", 64'(stall_cnt), 64'd3);
        flush = 0;

        // stall with out_valid low does not count
        step();
        chk("stall_invalid_cnt", 64'(stall_cnt), 64'd3);

        // saturation of the narrow counter, then reset mid-stall
        stall = 0; randomize_data(); in_valid = 1; step();
        stall = 1;
        for (int i = 0; i < 20; i++) begin
            randomize_data(); step();
        end
        chk("sat_cnt4", 64'(stall_cnt4), 64'hF);
        reset = 1; step();
        chk("rst_mid_valid", 64'(out_valid4), 64'd0);
        chk("rst_mid_cnt4", 64'(stall_cnt4), 64'd0);
        chk("rst_mid_a", 64'(op_a), 64'd0);
        reset = 0; stall = 0; randomize_data(); in_valid = 1; step();
        chk("post_rst_load", 64'(out_valid), 64'd1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            randomize_data();
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 35);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/operand_select_stage.md
OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width in bits (legal values 16 to 64).
REQ-002 The block SHALL have parameter IMM_W, default 16, giving the immediate field width in bits (must be less than WIDTH).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the ID stage presents a valid instruction.
REQ-007 The block SHALL have port stall, input, 1 bit: the hazard unit requests the stage to hold.
REQ-008 The block SHALL have port flush, input, 1 bit: the branch unit requests a bubble.
REQ-009 The block SHALL have port rs_data, input, WIDTH bits: register-file read port A.
REQ-010 The block SHALL have port rt_data, input, WIDTH bits: register-file read port B.
REQ-011 The block SHALL have port imm, input, IMM_W bits: raw immediate field.
REQ-012 The block SHALL have port ext_mode, input, 2 bits: 00 sign-extend, 01 zero-extend, 10 upper (imm placed at the MSBs, zero-filled below), 11 reserved (treated as 00).
REQ-013 The block SHALL have port alu_src, input, 1 bit: 1 selects the extended immediate for op_b, 0 selects forwarded rt.
REQ-014 The block SHALL have ports fwd_a and fwd_b, input, 2 bits each: 00 register file, 01 EX/MEM, 10 MEM/WB, 11 reserved (treated as 00).
REQ-015 The block SHALL have ports exmem_data and memwb_data, input, WIDTH bits each: forwarding sources.
REQ-016 The block SHALL have ports op_a and op_b, output, WIDTH bits each: registered ALU operands.
REQ-017 The block SHALL have port store_data, output, WIDTH bits: registered forwarded rt, independent of alu_src.
REQ-018 The block SHALL have port out_valid, output, 1 bit: the registered operands are valid.
REQ-019 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of stalled valid cycles.

Function
REQ-020 The block SHALL compute next_a as the fwd_a-selected source (rs_data, exmem_data or memwb_data), next_rt as the fwd_b-selected source (rt_data, exmem_data or memwb_data), and next_b as alu_src ? ext(imm) : next_rt.
REQ-021 The block SHALL produce ext(imm) as a WIDTH-bit value in every ext_mode, with no truncation.
REQ-022 The block SHALL give each edge exactly one outcome, with priority reset > flush > stall > load.
REQ-023 On a load edge, op_a, op_b and store_data SHALL take next_a, next_b and next_rt, and out_valid SHALL take in_valid: one cycle of latency.
REQ-024 On a stall edge, all output registers SHALL hold their values.
REQ-025 On a flush edge, out_valid SHALL clear to 0 and the data registers SHALL load 0, including when stall is high on the same edge.
REQ-026 stall_cnt SHALL increment on each stall edge where out_valid=1 and flush=0, and SHALL saturate at all-ones without wrapping.
REQ-027 When in_valid=0 on a load edge, out_valid SHALL be 0, and the data registers SHALL still load, so downstream logic must qualify on out_valid.

Reset
REQ-028 On a reset edge, op_a, op_b, store_data, out_valid and stall_cnt SHALL all become 0, regardless of stall or flush.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction, and the first edge after reset deasserts SHALL be a normal load.

Configuration
REQ-030 With OPSEL_FORWARDING_EN defined, fwd_a and fwd_b SHALL act as in REQ-014.
REQ-031 Without OPSEL_FORWARDING_EN, the block SHALL ignore fwd_a, fwd_b, exmem_data and memwb_data, take op_a from rs_data and next_rt from rt_data, and keep the port list unchanged.

Structure
REQ-032 A shared package opsel_pkg SHALL hold the ext_mode and fwd select encodings as named constants, and the default WIDTH and IMM_W.
REQ-033 Immediate extension SHALL be a combinational sub-module imm_extend (parameters WIDTH and IMM_W); forwarding muxes and registers SHALL stay in operand_select_stage.

Verification
REQ-034 The bench SHALL cover: imm=16'h8001, ext_mode=00, alu_src=1, WIDTH=32 -> op_b=32'hFFFF8001 one cycle later; with ext_mode=01 -> 32'h00008001; with ext_mode=10 -> 32'h80010000.
REQ-035 The bench SHALL cover: fwd_a=01, exmem_data=32'h12345678, rs_data=0 -> op_a=32'h12345678; fwd_b=10, alu_src=0, memwb_data=32'hA5A5A5A5 -> op_b=store_data=32'hA5A5A5A5.
REQ-036 The bench SHALL cover: load a valid op, then stall for 3 cycles while the inputs change -> outputs unchanged and stall_cnt=3.
REQ-037 The bench SHALL cover: stall=1 and flush=1 on the same edge -> out_valid=0, op_a=op_b=0, stall_cnt unchanged.
REQ-038 The bench SHALL cover: CNT_W=4 with 20 valid stall cycles -> stall_cnt=4'hF held; then reset for 1 cycle mid-stall -> all outputs 0 on the next edge.
REQ-039 The bench SHALL cover: a build without OPSEL_FORWARDING_EN, fwd_a=01, exmem_data=32'hDEADBEEF, rs_data=32'h1 -> op_a=32'h1.
